// File: rtl/prog_mem_loader_if.sv
// prog_mem_loader_if -- bus bundle between a program-memory loader and its
// user.
//
// Load side (byte stream in):
//   load_start      : pulse, begin a new program load at word address 0
//   load_end        : pulse, finish the current load
//   load_valid      : load_byte carries a byte this cycle
//   load_byte[7:0]  : program byte, little-endian within each word
//   load_ready      : the loader accepts a byte this cycle
//
// Fetch side (instruction words out):
//   fetch_req       : read request for program_counter
//   program_counter : fetch word address
//   data_out        : fetched word, zero when no result is presented
//   fetch_valid     : data_out holds a fetch result this cycle
//
// The master modport drives requests. The slave modport is the loader.
interface prog_mem_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              load_start;
  logic              load_end;
  logic              load_valid;
  logic [7:0]        load_byte;
  logic              load_ready;
  logic              fetch_req;
  logic [ADDR_W-1:0] program_counter;
  logic [DATA_W-1:0] data_out;
  logic              fetch_valid;

  modport master (
    output load_start, load_end, load_valid, load_byte,
    output fetch_req, program_counter,
    input  load_ready, data_out, fetch_valid
  );

  modport slave (
    input  load_start, load_end, load_valid, load_byte,
    input  fetch_req, program_counter,
    output load_ready, data_out, fetch_valid
  );
endinterface

// File: rtl/prog_mem_loader.sv
// prog_mem_loader -- instruction memory filled by a byte stream. Words are
// read back through a 1-cycle fetch port.
//
// Ports:
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset (control state only)
//   bus        : prog_mem_loader_if.slave, the load stream and the fetch port
//   busy       : high whenever the controller is not IDLE
//   load_count : words written in the current or last load
//                (saturates at 2^ADDR_W)
//   load_err   : sticky. Set by overflow or by a zero-padded partial final
//                word.
//
// Bytes fill a word from the least significant byte upward. A completed word
// is written on the edge that accepts its last byte. If load_end leaves a
// partial word, the PAD state writes it with the missing high bytes zeroed.
module prog_mem_loader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  prog_mem_loader_if.slave   bus,
  output logic               busy,
  output logic [ADDR_W:0]    load_count,
  output logic               load_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, PAD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              load_err_q, load_err_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [DATA_W-1:0] rd_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              fetch_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              full;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_cnt_d   = byte_cnt_q;
    word_d       = word_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    mem_we       = 1'b0;
    mem_wdata    = word_q;
    fetch_en     = 1'b0;
    full         = (load_count_q == FULL_COUNT);

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          state_d      = LOAD;
          addr_d       = '0;
          byte_cnt_d   = '0;
          word_d       = '0;
          load_count_d = '0;
          load_err_d   = 1'b0;
        end else begin
          // A fetch is serviced only when no load begins this cycle.
          fetch_en = bus.fetch_req;
        end
      end

      LOAD: begin
        if (bus.load_valid) begin
          for (int k = 0; k < BYTES; k++) begin
            if (byte_cnt_q == CNT_W'(k)) word_d[8*k +: 8] = bus.load_byte;
          end
          if (byte_cnt_q == CNT_W'(BYTES - 1)) begin
            mem_wdata  = word_d;
            byte_cnt_d = '0;
            // Clearing the buffer keeps a later partial word zero-filled in PAD.
            word_d     = '0;
            if (full) begin
              load_err_d = 1'b1;
            end else begin
              mem_we       = 1'b1;
              addr_d       = addr_q + 1'b1;
              load_count_d = load_count_q + 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
        // byte_cnt_d already counts a byte accepted this same cycle.
        if (bus.load_end) state_d = (byte_cnt_d != '0) ? PAD : IDLE;
      end

      PAD: begin
        state_d    = IDLE;
        load_err_d = 1'b1;
        byte_cnt_d = '0;
        word_d     = '0;
        if (!full) begin
          mem_we       = 1'b1;
          addr_d       = addr_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    fetch_valid_d = fetch_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      load_count_q  <= '0;
      load_err_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      load_count_q  <= load_count_d;
      load_err_q    <= load_err_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Memory contents are never reset. A write is suppressed on a reset edge,
  // so a load abandoned by reset cannot write anything more.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) mem[addr_q] <= mem_wdata;
    if (fetch_en) rd_data_q <= mem[bus.program_counter];
  end

  assign bus.load_ready  = (state_q == LOAD);
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.data_out    = fetch_valid_q ? rd_data_q : '0;
  assign busy            = (state_q != IDLE);
  assign load_count      = load_count_q;
  assign load_err        = load_err_q;
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader -- bench for prog_mem_loader.
// Part 1 applies a table of directed loads, each followed by read-back.
// Part 2 applies random loads with gaps and ignored control pulses, checked
// against a byte-queue reference model.
// Part 3 covers reset in the middle of a load.
// Part 4 fills and overflows a second instance with ADDR_W=2.
module tb_prog_mem_loader;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [7:0]        bq_t[$];
  typedef logic [ADDR_W-1:0] aq_t[$];
  typedef logic [15:0]       wq_t[$];

  typedef struct packed {
    logic [3:0]       nb;    // number of bytes in the load
    logic [5:0][7:0]  b;     // b[0] is sent first
    logic             co;    // load_end coincides with the last byte
    logic [11:0]      cnt;   // expected load_count
    logic             err;   // expected load_err
    logic [2:0][15:0] w;     // expected words 0..cnt-1
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  prog_mem_loader_if #(.ADDR_W(2), .DATA_W(16)) bus_s ();

  logic              busy, load_err, busy_s, load_err_s;
  logic [ADDR_W:0]   load_count;
  logic [2:0]        load_count_s;

  prog_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .busy(busy), .load_count(load_count), .load_err(load_err)
  );

  prog_mem_loader #(.ADDR_W(2), .DATA_W(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s),
    .busy(busy_s), .load_count(load_count_s), .load_err(load_err_s)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] model_mem [DEPTH];
  bit          known [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 0; bus.load_end = 0; bus.load_valid = 0; bus.load_byte = '0;
    bus.fetch_req = 0; bus.program_counter = '0;
    bus_s.load_start = 0; bus_s.load_end = 0; bus_s.load_valid = 0; bus_s.load_byte = '0;
    bus_s.fetch_req = 0; bus_s.program_counter = '0;
  endtask

  // Reference model: the whole byte list of a load becomes words, two bytes
  // per word, little-endian. An odd trailing byte is zero-padded.
  task automatic model_apply(input bq_t q, output int cnt, output bit err);
    int n;
    int nw;
    n = q.size();
    nw = (n + 1) / 2;
    cnt = 0;
    err = (n % 2) != 0;
    for (int w = 0; w < nw; w++) begin
      if (w < DEPTH) begin
        model_mem[w] = {((2*w + 1 < n) ? q[2*w + 1] : 8'h00), q[2*w]};
        known[w] = 1'b1;
        cnt++;
      end else begin
        err = 1'b1;
      end
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 64'(bus.load_ready), 64'd1);
    chk({tag, "_fv"},    64'(bus.fetch_valid), 64'd0);
    chk({tag, "_dout"},  64'(bus.data_out), 64'd0);
  endtask

  // Sends one load through the main instance and checks handshake and state
  // on the way. Random fetch and load_start pulses during LOAD must be ignored.
  task automatic do_load(input bq_t q, input bit co, input bit gaps);
    int n;
    n = q.size();
    bus.load_start = 1;
    bus.fetch_req = 1'($urandom_range(0, 1));
    bus.program_counter = ADDR_W'($urandom_range(0, DEPTH - 1));
    tick();
    bus.load_start = 0;
    chk("start_busy", 64'(busy), 64'd1);
    chk_quiet("start");
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          bus.load_valid = 0;
          bus.fetch_req = 1'($urandom_range(0, 1));
          bus.load_start = ($urandom_range(0, 7) == 0);
          tick();
          chk_quiet("gap");
        end
      end
      bus.load_valid = 1;
      bus.load_byte = q[i];
      bus.load_end = co && (i == n - 1);
      bus.fetch_req = (i == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      bus.load_start = ($urandom_range(0, 7) == 0);
      tick();
      if (!(co && i == n - 1)) chk_quiet("byte");
    end
    bus.load_valid = 0; bus.load_end = 0; bus.load_start = 0; bus.fetch_req = 0;
    if (!co || n == 0) begin
      bus.load_end = 1;
      tick();
      bus.load_end = 0;
    end
    if ((n % 2) != 0) begin
      chk("pad_busy",  64'(busy), 64'd1);
      chk("pad_ready", 64'(bus.load_ready), 64'd0);
      chk("pad_fv",    64'(bus.fetch_valid), 64'd0);
      tick();
    end
    chk("end_busy",  64'(busy), 64'd0);
    chk("end_ready", 64'(bus.load_ready), 64'd0);
  endtask

  // Back-to-back fetches with 1-cycle latency. load_end pulses in IDLE must
  // be ignored.
  task automatic do_fetch(input aq_t a, input wq_t e);
    for (int i = 0; i < a.size(); i++) begin
      bus.fetch_req = 1;
      bus.program_counter = a[i];
      bus.load_end = 1'($urandom_range(0, 1));
      tick();
      chk("fetch_valid", 64'(bus.fetch_valid), 64'd1);
      chk("fetch_data",  64'(bus.data_out), 64'(e[i]));
      $display("fetch pc=%0d data=%h exp=%h", a[i], bus.data_out, e[i]);
    end
    bus.fetch_req = 0;
    bus.load_end = 0;
    tick();
    chk("fetch_idle_fv",   64'(bus.fetch_valid), 64'd0);
    chk("fetch_idle_dout", 64'(bus.data_out), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    bq_t  q;
    aq_t  aq;
    wq_t  wq;
    int   mcnt;
    bit   merr;

    // Expected words are the byte pairs read little-endian.
    vecs[0] = '{nb: 4'd4, b: 48'h0000_5678_1234, co: 1'b0, cnt: 12'd2, err: 1'b0, w: 48'h0000_5678_1234};
    vecs[1] = '{nb: 4'd3, b: 48'h0000_00CC_BBAA, co: 1'b0, cnt: 12'd2, err: 1'b1, w: 48'h0000_00CC_BBAA};
    vecs[2] = '{nb: 4'd4, b: 48'h0000_4433_2211, co: 1'b1, cnt: 12'd2, err: 1'b0, w: 48'h0000_4433_2211};
    vecs[3] = '{nb: 4'd5, b: 48'h0005_0403_0201, co: 1'b1, cnt: 12'd3, err: 1'b1, w: 48'h0005_0403_0201};
    vecs[4] = '{nb: 4'd0, b: 48'h0,              co: 1'b0, cnt: 12'd0, err: 1'b0, w: 48'h0};
    vecs[5] = '{nb: 4'd1, b: 48'h0000_0000_009A, co: 1'b1, cnt: 12'd1, err: 1'b1, w: 48'h0000_0000_009A};
    vecs[6] = '{nb: 4'd6, b: 48'h1100_EFBE_ADDE, co: 1'b0, cnt: 12'd3, err: 1'b0, w: 48'h1100_EFBE_ADDE};

    // ---- reset state
    idle_inputs();
    rst_n = 0;
    repeat (3) tick();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_ready", 64'(bus.load_ready), 64'd0);
    chk("rst_fv",    64'(bus.fetch_valid), 64'd0);
    chk("rst_dout",  64'(bus.data_out), 64'd0);
    chk("rst_count", 64'(load_count), 64'd0);
    chk("rst_err",   64'(load_err), 64'd0);
    chk("rst_s_busy", 64'(busy_s), 64'd0);
    chk("rst_s_count", 64'(load_count_s), 64'd0);
    rst_n = 1;
    tick();

    // ---- part 1: table of directed loads
    for (int v = 0; v < 7; v++) begin
      q = {};
      for (int i = 0; i < int'(vecs[v].nb); i++) q.push_back(vecs[v].b[i]);
      do_load(q, vecs[v].co, (v % 2) == 1);
      model_apply(q, mcnt, merr);
      chk("vec_count", 64'(load_count), 64'(vecs[v].cnt));
      chk("vec_err",   64'(load_err),   64'(vecs[v].err));
      $display("vec %0d: bytes=%0d count=%0d err=%0d", v, vecs[v].nb, load_count, load_err);
      aq = {}; wq = {};
      for (int i = 0; i < int'(vecs[v].cnt); i++) begin
        aq.push_back(ADDR_W'(i));
        wq.push_back(vecs[v].w[i]);
      end
      if (aq.size() > 0) do_fetch(aq, wq);
    end

    // ---- part 2: random loads against the reference model
    for (int t = 0; t < 20; t++) begin
      int n;
      n = $urandom_range(0, 12);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
      do_load(q, 1'($urandom_range(0, 1)), 1'b1);
      model_apply(q, mcnt, merr);
      chk("rnd_count", 64'(load_count), 64'(mcnt));
      chk("rnd_err",   64'(load_err),   64'(merr));
      $display("rnd %0d: bytes=%0d count=%0d err=%0d", t, n, load_count, load_err);
      aq = {}; wq = {};
      for (int i = 0; i < 4; i++) begin
        int a;
        a = $urandom_range(0, 7);
        if (!known[a]) a = 0;
        aq.push_back(ADDR_W'(a));
        wq.push_back(model_mem[a]);
      end
      do_fetch(aq, wq);
    end

    // ---- part 3: reset during the first byte of word 1
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
    bus.load_valid = 1; bus.load_byte = 8'hEF; tick();
    bus.load_byte = 8'hBE; tick();
    bus.load_byte = 8'h55; tick();
    bus.load_valid = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(bus.load_ready), 64'd0);
    chk("mid_rst_count", 64'(load_count), 64'd0);
    chk("mid_rst_err",   64'(load_err), 64'd0);
    chk("mid_rst_fv",    64'(bus.fetch_valid), 64'd0);
    $display("reset mid-load: busy=%0d count=%0d", busy, load_count);
    model_mem[0] = 16'hBEEF;
    known[0] = 1'b1;
    aq = {ADDR_W'(0), ADDR_W'(1)};
    wq = {model_mem[0], model_mem[1]};
    do_fetch(aq, wq);

    // ---- part 4: overflow of a 4-word instance with 10 bytes
    bus_s.load_start = 1;
    tick();
    bus_s.load_start = 0;
    for (int i = 0; i < 10; i++) begin
      bus_s.load_valid = 1;
      bus_s.load_byte = 8'(i + 1);
      tick();
      chk("s_ready", 64'(bus_s.load_ready), 64'd1);
      if (i == 7) begin
        chk("s_full_count", 64'(load_count_s), 64'd4);
        chk("s_full_err",   64'(load_err_s), 64'd0);
      end
      if (i == 9) begin
        chk("s_ovf_count", 64'(load_count_s), 64'd4);
        chk("s_ovf_err",   64'(load_err_s), 64'd1);
      end
    end
    bus_s.load_valid = 0;
    bus_s.load_end = 1;
    tick();
    bus_s.load_end = 0;
    chk("s_end_busy",  64'(busy_s), 64'd0);
    chk("s_end_count", 64'(load_count_s), 64'd4);
    chk("s_end_err",   64'(load_err_s), 64'd1);
    $display("small overflow: count=%0d err=%0d", load_count_s, load_err_s);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ew;
      ew = {8'(2*i + 2), 8'(2*i + 1)};
      bus_s.fetch_req = 1;
      bus_s.program_counter = 2'(i);
      tick();
      chk("s_fetch_valid", 64'(bus_s.fetch_valid), 64'd1);
      chk("s_fetch_data",  64'(bus_s.data_out), 64'(ew));
      $display("small fetch pc=%0d data=%h exp=%h", i, bus_s.data_out, ew);
    end
    bus_s.fetch_req = 0;
    tick();
    chk("s_idle_fv", 64'(bus_s.fetch_valid), 64'd0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, meaning word address width (depth 2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 16, meaning instruction word width; a multiple of 8, at least 16; BYTES = DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port load_start  input  1  pulse, begins a program load at word address 0.
REQ-006 SHALL have port load_end  input  1  pulse, ends the current program load.
REQ-007 SHALL have port load_valid  input  1  load_byte is valid this cycle.
REQ-008 SHALL have port load_byte  input  8  program byte, little-endian within each word.
REQ-009 SHALL have port load_ready  output  1  block accepts a byte this cycle.
REQ-010 SHALL have port fetch_req  input  1  fetch request for program_counter.
REQ-011 SHALL have port program_counter  input  ADDR_W  fetch word address.
REQ-012 SHALL have port data_out  output  DATA_W  fetched instruction.
REQ-013 SHALL have port fetch_valid  output  1  data_out holds a fetch result this cycle.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port load_count  output  ADDR_W+1  words written in the current or last load.
REQ-016 SHALL have port load_err  output  1  sticky error: overflow or partial final word.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, PAD; IDLE->LOAD on load_start; LOAD->PAD on load_end with 1..BYTES-1 bytes pending; LOAD->IDLE on load_end with 0 bytes pending; PAD->IDLE unconditionally after one cycle.
REQ-018 SHALL hold load_ready = 1 exactly in LOAD; a byte is accepted when load_valid && load_ready.
REQ-019 SHALL place the k-th accepted byte of a word (k = 0..BYTES-1) in bits [8k+7:8k].
REQ-020 SHALL write the assembled word to memory at the load address on the edge accepting its BYTES-th byte, then increment the load address and load_count.
REQ-021 SHALL, in PAD, zero-fill the missing high bytes, write the word, increment load_count, and set load_err.
REQ-022 SHALL, when load_count equals 2^ADDR_W, discard further complete words without writing, hold load_count saturated, and set load_err; load_ready stays 1.
REQ-023 SHALL, when load_valid and load_end coincide in LOAD, accept the byte first and evaluate load_end including that byte.
REQ-024 SHALL, on load_start in IDLE, clear load address, byte counter, load_count and load_err; load_start in LOAD or PAD is ignored.
REQ-025 SHALL ignore load_end in IDLE and PAD.
REQ-026 SHALL service fetch only in IDLE with no load_start that cycle: fetch_req at edge N gives fetch_valid = 1 and data_out = mem[program_counter sampled at N] in the cycle after N (1-cycle latency, back-to-back supported).
REQ-027 SHALL drive fetch_valid = 0 and data_out = 0 in any cycle with no fetch result, including all of LOAD and PAD.
REQ-028 SHALL NOT initialise memory contents; only control state is reset.

Reset
REQ-029 SHALL, while rst_n = 0 at a rising edge, go to IDLE and clear load address, byte counter, load_count, load_err and fetch_valid; data_out = 0, busy = 0, load_ready = 0.
REQ-030 SHALL abandon a load on reset mid-operation; completed word writes persist, the pending partial word is discarded.

Verification
REQ-031 SHALL cover: DATA_W=16, load_start, bytes 0x34,0x12,0x78,0x56, load_end -> load_count=2, load_err=0; fetch pc=0 -> data_out 0x1234, pc=1 -> 0x5678, one cycle after request.
REQ-032 SHALL cover: load of 3 bytes 0xAA,0xBB,0xCC then load_end -> PAD one cycle, word 1 = 0x00CC, load_count=2, load_err=1.
REQ-033 SHALL cover: ADDR_W=2, load 10 bytes -> words 0..3 written, fifth word discarded, load_count=4, load_err=1.
REQ-034 SHALL cover: fetch_req during LOAD -> fetch_valid=0, data_out=0; load_valid with load_end on final byte -> word written, return to IDLE.
REQ-035 SHALL cover: rst_n low after 1 byte of word 1 -> IDLE, load_count=0, word 0 retained, word 1 unchanged.
